// File: rtl/intc.sv
// Eight-source interrupt controller.
// Each source is level or edge sensitive. Pending-and-enabled sources raise a
// registered irq, the CPU claims the lowest-numbered candidate by reading CLAIM,
// and signals end of interrupt by writing the claimed index back to CLAIM.
module intc (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  src,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  logic [7:0] pend_q, pend_d;
  logic [7:0] en_q, en_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] src_q;
  logic [2:0] claimed_q;
  logic       irq_q;
  state_e     state_q;

  logic       rd_en, wr_en;
  logic [7:0] cand;
  logic       cand_valid;
  logic [2:0] cand_idx;
  logic       claim, eoi;
  logic [7:0] w1c, claim_clr, rise;

  // Upper write-data bits carry no register state.
  logic       data_in_unused;
  assign data_in_unused = ^data_in[31:8];

  // Bus decode: a read wins over a simultaneous write.
  assign rd_en = cs & rd;
  assign wr_en = cs & wr & ~rd;

  // Candidate selection: lowest-numbered pending and enabled source wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cand     = pend_q & en_q;
    cand_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) cand_idx = 3'(i);
    end
  end
  assign cand_valid = |cand;

  assign claim = rd_en && (addr == ADDR_CLAIM) && cand_valid && (state_q == ASSERT);
  assign eoi   = wr_en && (addr == ADDR_CLAIM) && (data_in[2:0] == claimed_q)
                 && (state_q == SERVICE);

  // Next pending: level bits follow src, edge bits set on a rise and clear on
  // W1C or claim, with a same-cycle rise taking precedence over the clear.
  always_comb begin
    w1c       = (wr_en && (addr == ADDR_PENDING)) ? data_in[7:0] : 8'h00;
    claim_clr = claim ? (8'h01 << cand_idx) : 8'h00;
    rise      = src & ~src_q;
    pend_d    = (edge_q & ((pend_q & ~(w1c | claim_clr)) | rise)) | (~edge_q & src);
    en_d      = (wr_en && (addr == ADDR_ENABLE)) ? data_in[7:0] : en_q;
    edge_d    = (wr_en && (addr == ADDR_EDGE))   ? data_in[7:0] : edge_q;
  end

  // Same-cycle read data straight from register state.
  always_comb begin
    data_out = 32'h0;
    if (rd_en) begin
      case (addr)
        ADDR_PENDING: data_out = {24'h0, pend_q};
        ADDR_ENABLE:  data_out = {24'h0, en_q};
        ADDR_CLAIM:   data_out = cand_valid ? {1'b1, 28'h0, cand_idx} : 32'h0;
        ADDR_EDGE:    data_out = {24'h0, edge_q};
        default:      data_out = 32'h0;
      endcase
    end
  end

  // Registered src copy; it also loads during reset so a line already high
  // is not seen as a rising edge when reset releases.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    src_q <= src;
  end

  // Register file: pending, enable and edge-select bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 8'h00;
      en_q   <= 8'h00;
      edge_q <= 8'h00;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      edge_q <= edge_d;
    end
  end

  // Claim/EOI handshake FSM with registered irq, high exactly in ASSERT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      claimed_q <= 3'd0;
      irq_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_valid) begin
            state_q <= ASSERT;
            irq_q   <= 1'b1;
          end
        end
        ASSERT: begin
          if (claim) begin
            state_q   <= SERVICE;
            claimed_q <= cand_idx;
            irq_q     <= 1'b0;
          end else if (!cand_valid) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_intc.sv
// Directed testbench for intc: edge and level sources, priority, masking,
// W1C versus edge collisions, bad EOI, and reset in the middle of service.
module tb_intc;

  logic        clk;
  logic        rst;
  logic [7:0]  src;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        irq;

  int vectors;
  int miscompares;

  intc dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .cs       (cs),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input logic exp, input string tag);
    check(32'(irq), 32'(exp), tag);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs      = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    tick();
    cs      = 1'b0;
    wr      = 1'b0;
    data_in = 32'h0;
  endtask

  // Combinational read checked mid-cycle; the strobe is then clocked in,
  // which is what makes a CLAIM read take effect.
  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    cs   = 1'b1;
    rd   = 1'b1;
    addr = a;
    #1;
    check(data_out, exp, tag);
    tick();
    cs   = 1'b0;
    rd   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    src     = 8'h00;
    cs      = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = 2'd0;
    data_in = 32'h0;

    // Reset state
    tick();
    tick();
    check_irq(1'b0, "rst_irq");
    rd_chk(2'd0, 32'h0, "rst_pending");
    rst = 1'b0;
    tick();

    // Edge IRQ on src[2]: two-cycle latency, claim, EOI
    wr_reg(2'd1, 32'h04);
    wr_reg(2'd3, 32'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    check_irq(1'b0, "edge_irq_after_1");
    tick();
    check_irq(1'b1, "edge_irq_after_2");
    rd_chk(2'd2, 32'h8000_0002, "edge_claim");
    check_irq(1'b0, "edge_irq_in_service");
    rd_chk(2'd0, 32'h0, "edge_pending_cleared");
    wr_reg(2'd2, 32'd2);
    check_irq(1'b0, "edge_after_eoi");

    // Priority with level sources, reassert after EOI, drop without claim
    wr_reg(2'd3, 32'h00);
    wr_reg(2'd1, 32'hFF);
    src = 8'h82;
    tick();
    tick();
    check_irq(1'b1, "prio_irq");
    rd_chk(2'd2, 32'h8000_0001, "prio_claim1");
    check_irq(1'b0, "prio_service");
    tick();
    check_irq(1'b0, "prio_service_hold");
    wr_reg(2'd2, 32'd1);
    check_irq(1'b0, "prio_after_eoi");
    tick();
    check_irq(1'b1, "prio_reassert");
    rd_chk(2'd2, 32'h8000_0001, "prio_claim2");
    wr_reg(2'd2, 32'd1);
    check_irq(1'b0, "prio_after_eoi2");
    src = 8'h00;
    tick();
    check_irq(1'b1, "noclaim_assert");
    tick();
    check_irq(1'b0, "noclaim_drop_to_idle");

    // Masked edge source, then enable it
    wr_reg(2'd1, 32'h00);
    wr_reg(2'd3, 32'h20);
    src = 8'h20;
    tick();
    src = 8'h00;
    tick();
    tick();
    check_irq(1'b0, "masked_irq");
    check(data_out, 32'h0, "no_read_data_out");
    rd_chk(2'd0, 32'h20, "masked_pending");
    rd_chk(2'd2, 32'h0, "masked_claim_invalid");
    wr_reg(2'd1, 32'h20);
    check_irq(1'b0, "unmask_same_edge");
    tick();
    check_irq(1'b1, "unmask_irq");
    wr_reg(2'd0, 32'h20);
    tick();
    check_irq(1'b0, "w1c_drops_irq");

    // W1C colliding with a new edge: set wins
    wr_reg(2'd1, 32'h00);
    wr_reg(2'd3, 32'h28);
    src = 8'h08;
    tick();
    src = 8'h00;
    rd_chk(2'd0, 32'h08, "collide_pending_set");
    src     = 8'h08;
    cs      = 1'b1;
    wr      = 1'b1;
    addr    = 2'd0;
    data_in = 32'h08;
    tick();
    cs      = 1'b0;
    wr      = 1'b0;
    data_in = 32'h0;
    src     = 8'h00;
    rd_chk(2'd0, 32'h08, "collide_set_wins");
    wr_reg(2'd0, 32'h08);
    rd_chk(2'd0, 32'h00, "w1c_clears_edge");
    src = 8'h01;
    tick();
    wr_reg(2'd0, 32'h01);
    rd_chk(2'd0, 32'h01, "w1c_ignores_level");
    src = 8'h00;
    tick();

    // Read and write together: read honoured, write dropped; upper bits ignored
    cs      = 1'b1;
    rd      = 1'b1;
    wr      = 1'b1;
    addr    = 2'd1;
    data_in = 32'hFF;
    #1;
    check(data_out, 32'h0, "rdwr_read");
    tick();
    cs      = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    data_in = 32'h0;
    rd_chk(2'd1, 32'h0, "rdwr_no_write");
    wr_reg(2'd3, 32'hFFFF_FF28);
    rd_chk(2'd3, 32'h28, "edge_upper_ignored");

    // Bad EOI in service, then reset mid-service with src[4] held high
    wr_reg(2'd3, 32'h10);
    wr_reg(2'd1, 32'h10);
    src = 8'h10;
    tick();
    tick();
    check_irq(1'b1, "svc_irq");
    rd_chk(2'd2, 32'h8000_0004, "svc_claim4");
    check_irq(1'b0, "svc_irq_low");
    src = 8'h11;
    wr_reg(2'd1, 32'h11);
    wr_reg(2'd2, 32'd3);
    check_irq(1'b0, "bad_eoi_irq");
    tick();
    tick();
    check_irq(1'b0, "bad_eoi_stays_service");
    rd_chk(2'd0, 32'h01, "svc_pending");
    rst = 1'b1;
    tick();
    check_irq(1'b0, "mid_rst_irq");
    rd_chk(2'd0, 32'h0, "mid_rst_pending");
    rd_chk(2'd1, 32'h0, "mid_rst_enable");
    rst = 1'b0;
    wr_reg(2'd1, 32'h01);
    tick();
    check_irq(1'b1, "post_rst_no_eoi_needed");
    wr_reg(2'd3, 32'h10);
    wr_reg(2'd0, 32'h10);
    tick();
    tick();
    rd_chk(2'd0, 32'h01, "no_edge_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates occur on posedge clk.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port src, input, 8, interrupt request lines, synchronous to clk; src[0] is highest priority.
REQ-004 SHALL have port cs, input, 1, chip select for register access.
REQ-005 SHALL have ports rd and wr, input, 1 each, single-cycle read and write strobes, qualified by cs.
REQ-006 SHALL have port addr, input, 2, register select: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 EDGE.
REQ-007 SHALL have port data_in, input, 32, write data.
REQ-008 SHALL have port data_out, output, 32, read data.
REQ-009 SHALL have port irq, output, 1, registered interrupt request to the CPU.

Function
REQ-010 SHALL drive data_out combinationally from current register state when cs&rd, giving same-cycle read data; otherwise 32'h0.
REQ-011 SHALL return {24'h0, reg[7:0]} for reads of PENDING, ENABLE and EDGE.
REQ-012 SHALL return CLAIM as {valid, 28'h0, idx[2:0]} with valid in bit 31, where idx is the lowest-numbered bit of PENDING&ENABLE and valid=|(PENDING&ENABLE); with no candidate, CLAIM returns 32'h0.
REQ-013 SHALL make ENABLE[7:0] and EDGE[7:0] read/write; bits 31:8 are ignored on write.
REQ-014 SHALL set an edge source pending bit (EDGE[i]=1) on the cycle after src[i] transitions 0->1, sampled against a registered copy of src.
REQ-015 SHALL track a level source pending bit (EDGE[i]=0) as PENDING[i]=src[i] each cycle.
REQ-016 SHALL clear edge source PENDING bits written as 1 to PENDING (write-1-to-clear); such writes SHALL have no effect on level source bits.
REQ-017 SHALL let a set win over a clear in the same cycle, whether the clear comes from W1C or from a claim.
REQ-018 SHALL implement FSM states IDLE, ASSERT and SERVICE.
REQ-019 SHALL move IDLE->ASSERT at the posedge where PENDING&ENABLE is nonzero.
REQ-020 SHALL drive irq=1 exactly while in ASSERT.
REQ-021 SHALL move ASSERT->IDLE if PENDING&ENABLE becomes zero without a claim.
REQ-022 SHALL treat a claim as cs&rd&addr==2 with valid=1 while in ASSERT; at that posedge, the FSM SHALL latch idx into claimed[2:0], clear PENDING[idx] if edge, and move to SERVICE.
REQ-023 SHALL treat a CLAIM read with valid=0, or outside ASSERT, as a pure read with no state change.
REQ-024 SHALL move SERVICE->IDLE on an EOI, i.e. a write to CLAIM with data_in[2:0]==claimed; a mismatched EOI SHALL be ignored.
REQ-025 SHALL keep irq=0 in SERVICE regardless of new pending sources; those are re-evaluated once in IDLE.
REQ-026 SHALL leave the FSM unaffected when ENABLE or EDGE changes during SERVICE; EOI is still required.
REQ-027 SHALL honour rd and ignore wr when both are asserted in the same cycle.
REQ-028 SHALL give a minimum latency of 2 cycles from a src edge to irq=1: 1 cycle to pending, 1 cycle to ASSERT.

Reset
REQ-029 SHALL, on the rst posedge, clear PENDING, ENABLE, EDGE, claimed and irq, and set the FSM to IDLE.
REQ-030 SHALL load the registered src copy from src during reset, so a line already high produces no edge on reset release.
REQ-031 SHALL, when rst is asserted mid-service, abandon the claim; no EOI is required afterwards.

Verification
REQ-032 Edge IRQ: ENABLE=0x04, EDGE=0x04, pulse src[2] for 1 cycle -> irq=1 two cycles later; CLAIM read = 0x80000002; irq=0 and PENDING=0 next cycle; EOI write 2 -> IDLE.
REQ-033 Priority: ENABLE=0xFF, level src=0x82 -> CLAIM reads 0x80000001; after EOI 1 with src still 0x82 -> irq reasserts, next CLAIM again 0x80000001.
REQ-034 Masked: ENABLE=0x00, edge src[5] pulse -> PENDING=0x20, irq stays 0; write ENABLE=0x20 -> irq=1 next cycle.
REQ-035 Simultaneous: W1C 0x08 to PENDING in the same cycle as a new src[3] edge result -> PENDING[3] remains 1.
REQ-036 Bad EOI/reset: in SERVICE with claimed=4, write CLAIM 3 -> stays SERVICE, irq 0; assert rst with src[4] held high -> IDLE, PENDING=0, no edge pending after release.
